// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result log: occupancy FSM states and flag bit positions.
package alu_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PART  = 2'd1,
    S_FULL  = 2'd2
  } occ_state_e;

  localparam int unsigned FLAG_W   = 4;
  localparam int unsigned FLAG_V   = 3;
  localparam int unsigned FLAG_C   = 2;
  localparam int unsigned FLAG_NEG = 1;
  localparam int unsigned FLAG_Z   = 0;

endpackage

// File: rtl/edge_rise.sv
// One-register rising-edge detector; rise_c is high in the cycle d goes 0->1.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise_c = d & ~d_q;

endmodule

// File: rtl/alu_result_log.sv
// Circular log of recent ALU results with a scrollable view; STEP walks toward older entries.
// Build option: define ALU_LOG_FLAGS_EN to store and show the {V,C,Neg,Z} flags per entry.
module alu_result_log
  import alu_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK50M,
  input  logic                     RSTb,
  input  logic                     WR,
  input  logic [N-1:0]             DIN,
  input  logic [3:0]               FLAGS_IN,
  input  logic                     STEP,
  input  logic                     CLR,
  output logic [N-1:0]             DOUT,
  output logic [3:0]               FLAGS_OUT,
  output logic [$clog2(DEPTH)-1:0] IDX,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     EMPTY,
  output logic                     FULL
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
`ifdef ALU_LOG_FLAGS_EN
  localparam int unsigned EW = N + FLAG_W;
`else
  localparam int unsigned EW = N;
`endif

  occ_state_e    state, state_d;
  logic [AW-1:0] wr_ptr, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          wr_en;
  logic          step_rise;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] entry;
  logic [AW-1:0] rd_addr;
  logic [EW-1:0] rd_data;

  edge_rise u_step_edge (
    .clk    (CLK50M),
    .rst_n  (RSTb),
    .d      (STEP),
    .rise_c (step_rise)
  );

  always_ff @(posedge CLK50M or negedge RSTb) begin
    if (!RSTb) begin
      state   <= S_EMPTY;
      wr_ptr  <= '0;
      count_q <= '0;
      idx_q   <= '0;
    end else begin
      state   <= state_d;
      wr_ptr  <= wr_ptr_d;
      count_q <= count_d;
      idx_q   <= idx_d;
    end
  end

  // Clear beats write, write beats a scroll edge.
  always_comb begin
    state_d  = state;
    wr_ptr_d = wr_ptr;
    count_d  = count_q;
    idx_d    = idx_q;
    wr_en    = 1'b0;
    if (CLR) begin
      state_d  = S_EMPTY;
      wr_ptr_d = '0;
      count_d  = '0;
      idx_d    = '0;
    end else if (WR) begin
      wr_en    = 1'b1;
      wr_ptr_d = wr_ptr + AW'(1);
      idx_d    = '0;
      case (state)
        S_EMPTY: begin
          state_d = S_PART;
          count_d = CW'(1);
        end
        S_PART: begin
          count_d = count_q + CW'(1);
          if (count_q == CW'(DEPTH - 1)) state_d = S_FULL;
        end
        default: count_d = CW'(DEPTH);
      endcase
    end else if (step_rise) begin
      if (count_q <= CW'(1))                         idx_d = '0;
      else if ({1'b0, idx_q} == count_q - CW'(1))    idx_d = '0;
      else                                           idx_d = idx_q + AW'(1);
    end
  end

`ifdef ALU_LOG_FLAGS_EN
  assign entry = {DIN, FLAGS_IN};
`else
  assign entry = DIN;
  logic unused_flags_in;
  assign unused_flags_in = ^FLAGS_IN;
`endif

  // Storage needs no reset: an empty log masks whatever the array holds.
  always_ff @(posedge CLK50M) begin
    if (wr_en) mem[wr_ptr] <= entry;
  end

  assign rd_addr = wr_ptr - AW'(1) - idx_q;
  assign rd_data = mem[rd_addr];

  assign EMPTY = (state == S_EMPTY);
  assign FULL  = (state == S_FULL);
  assign COUNT = count_q;
  assign IDX   = idx_q;
  assign DOUT  = EMPTY ? '0 : rd_data[EW-1 -: N];
`ifdef ALU_LOG_FLAGS_EN
  assign FLAGS_OUT = EMPTY ? 4'b0000 : rd_data[FLAG_W-1:0];
`else
  assign FLAGS_OUT = 4'b0000;
`endif

endmodule

// File: doc/alu_result_log.md
ALU_RESULT_LOG -- requirements
Module: alu_result_log

Interface
REQ-001 The block SHALL have parameter N, default 8: width of each stored ALU result.
REQ-002 The block SHALL have parameter DEPTH, default 4: number of log entries; power of two, >= 2.
REQ-003 The block SHALL have port CLK50M  input  1  sole clock; all state on its rising edge.
REQ-004 The block SHALL have port RSTb  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port WR  input  1  single-cycle write strobe, same cycle as C-register enable.
REQ-006 The block SHALL have port DIN  input  N  ALU result to log.
REQ-007 The block SHALL have port FLAGS_IN  input  4  {V,C,Neg,Z} accompanying DIN.
REQ-008 The block SHALL have port STEP  input  1  debounced level; each rising edge scrolls one entry older.
REQ-009 The block SHALL have port CLR  input  1  synchronous clear of the log.
REQ-010 The block SHALL have port DOUT  output  N  result of the viewed entry.
REQ-011 The block SHALL have port FLAGS_OUT  output  4  flags of the viewed entry.
REQ-012 The block SHALL have port IDX  output  log2(DEPTH)  age of viewed entry; 0 = newest.
REQ-013 The block SHALL have port COUNT  output  log2(DEPTH)+1  number of valid entries.
REQ-014 The block SHALL have ports EMPTY and FULL  output  1 each  COUNT==0 and COUNT==DEPTH.

Function
REQ-015 Storage SHALL be a circular buffer: write pointer, COUNT, view offset.
REQ-016 WR with CLR low SHALL store {DIN,FLAGS_IN} at write pointer, advance pointer mod DEPTH, COUNT+1 saturating at DEPTH.
REQ-017 WR when FULL SHALL overwrite the oldest entry; COUNT stays DEPTH.
REQ-018 Every accepted write SHALL force IDX to 0.
REQ-019 DOUT/FLAGS_OUT SHALL show the new entry the cycle after WR (latency 1).
REQ-020 STEP SHALL be edge-detected internally via one register; only a 0->1 transition counts.
REQ-021 A STEP edge SHALL increment IDX, wrapping to 0 after COUNT-1; with COUNT<=1, IDX stays 0.
REQ-022 WR and a STEP edge in the same cycle: write SHALL win, IDX=0, edge discarded.
REQ-023 CLR SHALL zero pointers, COUNT, IDX next cycle; CLR with WR SHALL drop the write.
REQ-024 EMPTY SHALL force DOUT and FLAGS_OUT to 0 regardless of array contents.
REQ-025 Occupancy FSM SHALL have states S_EMPTY, S_PART, S_FULL: EMPTY->PART on WR; PART->FULL on WR at COUNT==DEPTH-1; FULL holds on WR; any->EMPTY on CLR.
REQ-026 DOUT/FLAGS_OUT SHALL be a combinational read of entry (wr_ptr-1-IDX) mod DEPTH.

Reset
REQ-027 RSTb low SHALL asynchronously clear pointers, COUNT, IDX, STEP edge register, FSM to S_EMPTY.
REQ-028 Outputs during and after reset: DOUT=0, FLAGS_OUT=0, IDX=0, COUNT=0, EMPTY=1, FULL=0.
REQ-029 Array contents SHALL need no reset; REQ-024 masks them.
REQ-030 Reset mid-scroll or mid-write SHALL discard all entries; a WR coincident with RSTb release SHALL be ignored.

Configuration
REQ-031 Macro ALU_LOG_FLAGS_EN defined: flags stored per entry and driven on FLAGS_OUT.
REQ-032 Macro ALU_LOG_FLAGS_EN undefined: no flag storage, FLAGS_IN ignored, FLAGS_OUT tied 4'b0000.

Structure
REQ-033 Shared package alu_pkg SHALL hold the FSM state enum (S_EMPTY/S_PART/S_FULL) and flag bit-index constants FLAG_V=3, FLAG_C=2, FLAG_NEG=1, FLAG_Z=0.
REQ-034 Sub-module edge_rise (one-register rising-edge detector, async active-low reset) SHALL be used for STEP.

Verification
REQ-035 Reset, then WR DIN=8'h12 FLAGS_IN=4'b0001 -> next cycle DOUT=8'h12, FLAGS_OUT=4'b0001, COUNT=1, EMPTY=0.
REQ-036 Writes 8'h01..8'h05 (DEPTH=4) -> FULL=1, COUNT=4, DOUT=8'h05; three STEP edges -> 8'h04, 8'h03, 8'h02; fourth -> IDX=0, 8'h05.
REQ-037 STEP edge and WR DIN=8'hAA same cycle with IDX=2 -> IDX=0, DOUT=8'hAA.
REQ-038 CLR and WR same cycle with COUNT=3 -> COUNT=0, EMPTY=1, DOUT=0.
REQ-039 STEP held high 10 cycles after one 0->1 -> IDX advances exactly once.
REQ-040 RSTb low mid-sequence with COUNT=3, IDX=1 -> same cycle COUNT=0, IDX=0, DOUT=0; repeat with ALU_LOG_FLAGS_EN undefined -> FLAGS_OUT always 0.
